// File: rtl/weight_bram_pkg.sv
// Shared constants and FSM state encoding for the weight streaming RAM.
package weight_bram_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 28;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BURST = 2'b01,
    ST_DRAIN = 2'b10
  } state_t;

endpackage

// File: rtl/sdp_bram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Array is never reset so contents survive RST_N.
module sdp_bram #(
  parameter int    DATA_W    = 16,
  parameter int    DEPTH     = 28,
  parameter int    ADDR_W    = 5,
  parameter string INIT_FILE = "weight.txt"
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Synchronous read port
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/weight_stream_bram.sv
// Weight store with a load port and a burst read stream behind a
// two-entry skid buffer (DO register plus one skid slot).
module weight_stream_bram
  import weight_bram_pkg::*;
#(
  parameter int    DATA_W    = DATA_W_DEF,
  parameter int    DEPTH     = DEPTH_DEF,
  parameter int    ADDR_W    = ADDR_W_DEF,
  parameter string INIT_FILE = "weight.txt"
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              WR_EN,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [DATA_W-1:0] WR_DATA,
  output logic              WR_ERR,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE,
  input  logic [ADDR_W:0]   LEN,
  output logic              BUSY,
  output logic [DATA_W-1:0] DO,
  output logic              DO_VALID,
  input  logic              DO_READY,
  output logic              DO_LAST
);

  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH-1);

  state_t            state;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   remain;
  logic              rd_v;
  logic              rd_last;
  logic [DATA_W-1:0] rd_data;
  logic              skid_v;
  logic              skid_last;
  logic [DATA_W-1:0] skid_data;

  logic       wr_ok;
  logic       start_ok;
  logic       xfer;
  logic       load_out;
  logic       issue;
  logic [1:0] occ;

  // Request qualification and read-issue flow control. A read is issued
  // only if, after this edge, at most one word sits in DO/skid, so the
  // word returning next cycle always has a slot even if DO_READY drops.
  always_comb begin
    wr_ok    = WR_EN && (state == ST_IDLE) && ({1'b0, WR_ADDR} < DEPTH_C);
    start_ok = START && (state == ST_IDLE) && (LEN != '0) && ({1'b0, BASE} < DEPTH_C);
    xfer     = DO_VALID && DO_READY;
    load_out = !DO_VALID || DO_READY;
    occ      = 2'(DO_VALID) + 2'(skid_v) + 2'(rd_v);
    issue    = (state == ST_BURST) && (occ <= (2'(xfer) + 2'd1));
  end

  sdp_bram #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk    (CLK),
    .wr_en  (wr_ok),
    .wr_addr(WR_ADDR),
    .wr_data(WR_DATA),
    .rd_en  (issue),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  // Burst FSM with address/length counters and write-reject flag
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= ST_IDLE;
      BUSY    <= 1'b0;
      rd_addr <= '0;
      remain  <= '0;
      rd_v    <= 1'b0;
      rd_last <= 1'b0;
      WR_ERR  <= 1'b0;
    end else begin
      WR_ERR  <= WR_EN && !wr_ok;
      rd_v    <= issue;
      rd_last <= issue && (remain == (ADDR_W+1)'(1));
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state   <= ST_BURST;
            BUSY    <= 1'b1;
            rd_addr <= BASE;
            remain  <= LEN;
          end
        end
        ST_BURST: begin
          if (issue) begin
            rd_addr <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + 1'b1;
            remain  <= remain - 1'b1;
            if (remain == (ADDR_W+1)'(1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (xfer && DO_LAST) begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

  // Output register plus skid slot; skid only fills while DO is stalled
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      DO        <= '0;
      DO_VALID  <= 1'b0;
      DO_LAST   <= 1'b0;
      skid_v    <= 1'b0;
      skid_last <= 1'b0;
      skid_data <= '0;
    end else if (load_out) begin
      if (skid_v) begin
        DO        <= skid_data;
        DO_VALID  <= 1'b1;
        DO_LAST   <= skid_last;
        skid_v    <= rd_v;
        skid_data <= rd_data;
        skid_last <= rd_last;
      end else if (rd_v) begin
        DO       <= rd_data;
        DO_VALID <= 1'b1;
        DO_LAST  <= rd_last;
      end else begin
        DO_VALID <= 1'b0;
        DO_LAST  <= 1'b0;
      end
    end else if (rd_v) begin
      skid_data <= rd_data;
      skid_last <= rd_last;
      skid_v    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_weight_stream_bram.sv
// Directed bench for weight_stream_bram: RAM is loaded through the write
// port with word i = i+1, then bursts are checked against a local model.
module tb_weight_stream_bram;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 28;
  localparam int ADDR_W = 5;

  logic              CLK      = 1'b0;
  logic              RST_N    = 1'b0;
  logic              WR_EN    = 1'b0;
  logic [ADDR_W-1:0] WR_ADDR  = '0;
  logic [DATA_W-1:0] WR_DATA  = '0;
  logic              START    = 1'b0;
  logic [ADDR_W-1:0] BASE     = '0;
  logic [ADDR_W:0]   LEN      = '0;
  logic              DO_READY = 1'b1;
  logic              WR_ERR;
  logic              BUSY;
  logic [DATA_W-1:0] DO;
  logic              DO_VALID;
  logic              DO_LAST;

  int vectors     = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] model [DEPTH];
  logic [DATA_W-1:0] exp_q [$];
  int                got_cnt    = 0;
  bit                stall_mode = 1'b0;
  bit                stalled    = 1'b0;
  logic [DATA_W-1:0] held       = '0;

  weight_stream_bram #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .INIT_FILE("")
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .WR_EN   (WR_EN),
    .WR_ADDR (WR_ADDR),
    .WR_DATA (WR_DATA),
    .WR_ERR  (WR_ERR),
    .START   (START),
    .BASE    (BASE),
    .LEN     (LEN),
    .BUSY    (BUSY),
    .DO      (DO),
    .DO_VALID(DO_VALID),
    .DO_READY(DO_READY),
    .DO_LAST (DO_LAST)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stream monitor: every transfer is matched against the expected queue,
  // and a stalled word must still be presented unchanged next cycle.
  always @(negedge CLK) begin
    if (RST_N) begin
      if (stalled) begin
        check("hold_valid", 32'(DO_VALID), 32'd1);
        check("hold_data", 32'(DO), 32'(held));
      end
      if (DO_VALID && DO_READY) begin
        check("xfer_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          check("do_data", 32'(DO), 32'(exp_q.pop_front()));
          check("do_last", 32'(DO_LAST), 32'(exp_q.size() == 0));
          got_cnt++;
        end
      end
      stalled = DO_VALID && !DO_READY;
      held    = DO;
    end else begin
      stalled = 1'b0;
    end
  end

  // Consumer ready: constant high, or the repeating 1,0,0,1 pattern
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge CLK);
      #1;
      DO_READY = stall_mode ? ((ph == 0) || (ph == 3)) : 1'b1;
      ph = (ph + 1) % 4;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr_word(input int a, input logic [DATA_W-1:0] d, input logic exp_err, input string tag);
    WR_EN   = 1'b1;
    WR_ADDR = ADDR_W'(a);
    WR_DATA = d;
    tick();
    WR_EN = 1'b0;
    @(negedge CLK);
    check(tag, 32'(WR_ERR), 32'(exp_err));
    tick();
  endtask

  task automatic start_burst(input int base, input int len);
    START = 1'b1;
    BASE  = ADDR_W'(base);
    LEN   = (ADDR_W+1)'(len);
    tick();
    START = 1'b0;
  endtask

  task automatic expect_burst(input int base, input int len);
    for (int i = 0; i < len; i++) exp_q.push_back(model[(base + i) % DEPTH]);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    for (n = 0; n < 300; n++) begin
      @(negedge CLK);
      if (!BUSY && exp_q.size() == 0) break;
    end
    check(tag, (n < 300) ? 32'd1 : 32'd0, 32'd1);
    tick();
  endtask

  task automatic quiet_check(input string tag);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check({tag, "_busy"}, 32'(BUSY), 32'd0);
      check({tag, "_valid"}, 32'(DO_VALID), 32'd0);
    end
    tick();
  endtask

  initial begin
    int bcnt;
    int vcnt;
    int n;

    repeat (2) @(posedge CLK);
    #1;
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_valid", 32'(DO_VALID), 32'd0);
    check("rst_last", 32'(DO_LAST), 32'd0);
    check("rst_wr_err", 32'(WR_ERR), 32'd0);
    check("rst_do", 32'(DO), 32'd0);
    RST_N = 1'b1;
    tick();

    for (int i = 0; i < DEPTH; i++) begin
      model[i] = DATA_W'(i + 1);
      wr_word(i, DATA_W'(i + 1), 1'b0, "load_err");
    end
    wr_word(28, 16'hDEAD, 1'b1, "wr_oob_err");

    // Full-depth burst at full rate
    expect_burst(0, 28);
    start_burst(0, 28);
    @(negedge CLK);
    check("lat_edge1", 32'(DO_VALID), 32'd0);
    @(negedge CLK);
    check("lat_edge2", 32'(DO_VALID), 32'd0);
    bcnt = 0;
    vcnt = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge CLK);
      if (!BUSY) break;
      bcnt++;
      if (DO_VALID) vcnt++;
    end
    check("full_busy_cycles", 32'(bcnt), 32'd28);
    check("full_valid_cycles", 32'(vcnt), 32'd28);
    check("full_drained", 32'(exp_q.size()), 32'd0);
    check("full_valid_after", 32'(DO_VALID), 32'd0);
    tick();

    // Address wrap
    expect_burst(26, 4);
    start_burst(26, 4);
    wait_idle("wrap_done");
    expect_burst(27, 2);
    start_burst(27, 2);
    wait_idle("last_addr_done");

    // Back-pressure, with a START that must be ignored mid-burst
    got_cnt    = 0;
    stall_mode = 1'b1;
    expect_burst(5, 6);
    start_burst(5, 6);
    repeat (3) tick();
    START = 1'b1;
    BASE  = '0;
    LEN   = 6'd3;
    tick();
    START = 1'b0;
    wait_idle("stall_done");
    check("stall_count", 32'(got_cnt), 32'd6);
    stall_mode = 1'b0;
    repeat (4) tick();

    // Write rejected while busy, accepted when idle
    expect_burst(0, 8);
    start_burst(0, 8);
    wr_word(3, 16'h00AA, 1'b1, "wr_busy_err");
    wait_idle("wr_busy_done");
    wr_word(3, 16'h00AA, 1'b0, "wr_idle_err");
    model[3] = 16'h00AA;
    expect_burst(2, 3);
    start_burst(2, 3);
    wait_idle("wr_idle_done");

    // Write coincident with accepted START lands before the read
    model[4] = 16'h0BEE;
    expect_burst(4, 1);
    WR_EN   = 1'b1;
    WR_ADDR = 5'd4;
    WR_DATA = 16'h0BEE;
    START   = 1'b1;
    BASE    = 5'd4;
    LEN     = 6'd1;
    tick();
    WR_EN = 1'b0;
    START = 1'b0;
    @(negedge CLK);
    check("wr_start_err", 32'(WR_ERR), 32'd0);
    tick();
    wait_idle("wr_start_done");

    // Reset after the third word of a ten-word burst
    expect_burst(0, 10);
    start_burst(0, 10);
    for (n = 0; n < 50; n++) begin
      @(negedge CLK);
      if (DO_VALID && DO_READY && DO == 16'd3) break;
    end
    check("rst_reach_word3", (n < 50) ? 32'd1 : 32'd0, 32'd1);
    tick();
    RST_N = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_valid", 32'(DO_VALID), 32'd0);
    check("midrst_do", 32'(DO), 32'd0);
    check("midrst_last", 32'(DO_LAST), 32'd0);
    check("midrst_busy", 32'(BUSY), 32'd0);
    tick();
    check("midrst_hold_valid", 32'(DO_VALID), 32'd0);
    RST_N = 1'b1;
    expect_burst(0, 2);
    start_burst(0, 2);
    @(negedge CLK);
    check("start_after_rst", 32'(BUSY), 32'd1);
    wait_idle("post_rst_done");
    expect_burst(2, 3);
    start_burst(2, 3);
    wait_idle("ram_kept_done");

    // Rejected STARTs
    start_burst(0, 0);
    quiet_check("len0");
    start_burst(28, 4);
    quiet_check("base_oob");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
